// File: rtl/riscv_memory_responder.sv
// riscv_memory_responder: word-RAM slave for the core's memory request port.
// Each accepted request gets a one-cycle ready pulse after LATENCY cycles.
module riscv_memory_responder #(
    parameter int unsigned WORDS        = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] memory_address,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] memory_out,
    output logic [31:0] memory_in,
    output logic        memory_ready,
    output logic [31:0] memory_address_requested,
    output logic        memory_error
);
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] data_q;
    logic [31:0] addr_q;
    logic        perr_q;
    logic [31:0] pdata_q;
    logic [31:0] paddr_q;
    logic [31:0] mem_q [WORDS];

    logic [31:0] word_idx;
    logic [31:0] req_addr;
    logic [31:0] resp_data;
    logic [AW-1:0] ram_idx;
    logic        req;
    logic        accept;
    logic        in_range;
    logic        do_write;

    // Unsigned difference makes addresses below the base wrap out of range.
    always_comb begin
        word_idx = (memory_address - BASE_ADDRESS) >> 2;
        in_range = word_idx < WORDS;
        ram_idx  = word_idx[AW-1:0];
        req_addr = {memory_address[31:2], 2'b00};
        req      = memory_read | memory_write;
        accept   = req & reset & (state_q != S_WAIT);
        do_write = accept & memory_write & in_range;
        if (memory_write) begin
            resp_data = memory_out;
        end else if (in_range) begin
            resp_data = mem_q[ram_idx];
        end else begin
            resp_data = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_q[ram_idx] <= memory_out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            perr_q  <= 1'b0;
            pdata_q <= '0;
            paddr_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept && LATENCY == 1) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        err_q   <= ~in_range;
                        data_q  <= resp_data;
                        addr_q  <= req_addr;
                    end else if (accept) begin
                        state_q <= S_WAIT;
                        cnt_q   <= 4'(LATENCY - 1);
                        perr_q  <= ~in_range;
                        pdata_q <= resp_data;
                        paddr_q <= req_addr;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        err_q   <= perr_q;
                        data_q  <= pdata_q;
                        addr_q  <= paddr_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign memory_ready             = ready_q;
    assign memory_error             = err_q;
    assign memory_in                = data_q;
    assign memory_address_requested = addr_q;
endmodule

// File: doc/riscv_memory_responder.md
Name: riscv_memory_responder

Overview:
- Memory-side responder for the core's single-word memory request interface, i.e. the slave that cache controllers drive.
- Accepts word-aligned read and write requests and backs them with an internal word RAM.
- Answers each accepted request with a one-cycle memory_ready pulse after a configurable latency, echoing the serviced address.
- Used as main memory in simulation and on FPGA builds.

Parameters:
- WORDS, 1024: RAM depth in 32-bit words.
- LATENCY, 1: cycles from accepting edge to the ready cycle; legal range 1..15.
- BASE_ADDRESS, 32'h0000_0000: byte address of word 0; must be WORDS*4-aligned.

Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- memory_address  in  32: request byte address; bits [1:0] ignored.
- memory_read  in  1: read request.
- memory_write  in  1: write request (full word).
- memory_out  in  32: write data from initiator.
- memory_in  out  32: read data to initiator.
- memory_ready  out  1: response valid, one cycle per accepted request.
- memory_address_requested  out  32: word-aligned address of the request being answered.
- memory_error  out  1: accepted request was outside the RAM window; valid with memory_ready.

Behaviour:
- Reset (reset=0, async):
  - State to IDLE; latency counter to 0.
  - memory_ready=0, memory_error=0, memory_in=0, memory_address_requested=0.
  - RAM contents are not cleared.
- Reset asserted mid-request aborts that request with no response.
  - A write already accepted at an earlier edge stays committed.
- States:
  - IDLE: no request outstanding.
  - WAIT: counting down LATENCY-1 cycles; entered only when LATENCY>1.
  - RESP: memory_ready=1 for this one cycle.
- Acceptance:
  - A request (memory_read|memory_write) is accepted at a rising edge when state is IDLE or RESP.
  - Requests during WAIT are ignored with no side effects; the initiator keeps them asserted until serviced.
- Transitions:
  - IDLE/RESP with request: to RESP if LATENCY=1, else to WAIT with count=LATENCY-1.
  - IDLE/RESP without request: to IDLE.
  - WAIT: decrement each cycle; when count reaches 1, go to RESP at the next edge.
- Timing: memory_ready is high exactly in the cycle following edge E0+LATENCY-1, where E0 is the accepting edge.
  - LATENCY=1 sustains one request per cycle back-to-back.
- Address handling:
  - Captured at acceptance; word index = (memory_address-BASE_ADDRESS)>>2.
  - In range iff 0 <= index < WORDS, using unsigned compare of the difference.
- Write:
  - Full 32-bit memory_out stored at the accepting edge.
  - Response carries memory_in = written word.
- Read:
  - RAM word read at the accepting edge and held in a response register.
  - A write accepted at edge N is visible to a read accepted at edge N+1.
- memory_read and memory_write both high: treated as a write.
- Out of range:
  - Write is dropped; read returns 0.
  - memory_error=1 in the RESP cycle; the request still completes with memory_ready.
- Outside RESP cycles: memory_in=0, memory_error=0, memory_address_requested keeps the last served value.
- memory_address_requested = {captured address[31:2], 2'b00} during RESP.
- No byte enables: the initiator merges partial writes before issuing them.

Test Plan:
- Reset, LATENCY=1: write 32'hDEADBEEF to address 0x10 at edge 1, read 0x12 at edge 2 -> ready in cycles 2 and 3; cycle 3 has memory_in=32'hDEADBEEF and memory_address_requested=0x10.
- LATENCY=3: read 0x20 held continuously -> single ready pulse 3 cycles after acceptance; the held request is re-accepted in the RESP cycle, giving a pulse every 3 cycles; no extra pulses during WAIT.
- Read and write both asserted, address 0x40, data 32'h12345678 -> treated as write; response memory_in=32'h12345678; a following read of 0x40 returns the same value.
- BASE_ADDRESS=32'h8000_0000, WORDS=16: read 0x8000_0040 -> memory_error=1, memory_in=0; write to 0x7FFF_FFFC -> error, RAM unchanged.
- LATENCY=4: reset pulled low 2 cycles after accepting a read -> memory_ready stays 0 and the outputs clear immediately (async); after release, a new read completes normally.
- Back-to-back LATENCY=1 stream of 8 reads at 0x0..0x1C after 8 writes of values 1..8 -> 8 consecutive ready cycles returning 1..8 in order.
